// File: rtl/vx_lsu_csr_bridge.sv
// rtl/vx_lsu_csr_bridge.sv - serializes multi-lane LSU CSR requests into single-lane CSR accesses
module vx_lsu_csr_bridge #(
    parameter int NUM_LANES  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int TAG_WIDTH  = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [1:0]                      req_op,
    input  logic [NUM_LANES-1:0]            req_mask,
    input  logic [NUM_LANES*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] req_data,
    input  logic [TAG_WIDTH-1:0]            req_tag,
    output logic                            csr_read_enable,
    output logic [ADDR_WIDTH-1:0]           csr_read_addr,
    input  logic [DATA_WIDTH-1:0]           csr_read_data,
    output logic                            csr_write_enable,
    output logic [ADDR_WIDTH-1:0]           csr_write_addr,
    output logic [DATA_WIDTH-1:0]           csr_write_data,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [NUM_LANES-1:0]            rsp_mask,
    output logic [NUM_LANES*DATA_WIDTH-1:0] rsp_data,
    output logic [TAG_WIDTH-1:0]            rsp_tag
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_SET   = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;

    state_t                          state;
    logic [1:0]                      op_q;
    logic [NUM_LANES-1:0]            mask_q;
    logic [NUM_LANES-1:0]            pending;
    logic [NUM_LANES*ADDR_WIDTH-1:0] addr_q;
    logic [NUM_LANES*DATA_WIDTH-1:0] data_q;
    logic [NUM_LANES*DATA_WIDTH-1:0] rsp_data_q;
    logic [TAG_WIDTH-1:0]            tag_q;
    logic                            ready_q;
    logic                            valid_q;

    logic [NUM_LANES-1:0]  lane_sel;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [DATA_WIDTH-1:0] cur_data;
    logic                  active;

    // Descending scan so the lowest pending lane is the one that sticks.
    always_comb begin
        lane_sel = '0;
        cur_addr = '0;
        cur_data = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (pending[i]) begin
                lane_sel    = '0;
                lane_sel[i] = 1'b1;
                cur_addr    = addr_q[i*ADDR_WIDTH +: ADDR_WIDTH];
                cur_data    = data_q[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Reset suppresses strobes at once so a lane in flight is never committed.
    assign active           = (state == ACCESS) && !reset;
    assign csr_read_enable  = active;
    assign csr_read_addr    = active ? cur_addr : '0;
    assign csr_write_enable = active && (op_q != OP_READ);
    assign csr_write_addr   = csr_write_enable ? cur_addr : '0;

    always_comb begin
        csr_write_data = '0;
        if (csr_write_enable) begin
            case (op_q)
                OP_WRITE: csr_write_data = cur_data;
                OP_SET:   csr_write_data = csr_read_data | cur_data;
                OP_CLEAR: csr_write_data = csr_read_data & ~cur_data;
                default:  csr_write_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            op_q       <= '0;
            mask_q     <= '0;
            pending    <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            rsp_data_q <= '0;
            tag_q      <= '0;
            ready_q    <= 1'b1;
            valid_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q       <= req_op;
                        mask_q     <= req_mask;
                        pending    <= req_mask;
                        addr_q     <= req_addr;
                        data_q     <= req_data;
                        tag_q      <= req_tag;
                        rsp_data_q <= '0;
                        ready_q    <= 1'b0;
                        if (req_mask != '0) begin
                            state <= ACCESS;
                        end else begin
                            state   <= RESPOND;
                            valid_q <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    pending <= pending & ~lane_sel;
                    for (int i = 0; i < NUM_LANES; i++) begin
                        if (lane_sel[i]) begin
                            rsp_data_q[i*DATA_WIDTH +: DATA_WIDTH] <= csr_read_data;
                        end
                    end
                    if ((pending & ~lane_sel) == '0) begin
                        state   <= RESPOND;
                        valid_q <= 1'b1;
                    end
                end
                RESPOND: begin
                    if (rsp_ready) begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = valid_q;
    assign rsp_mask  = mask_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_tag   = tag_q;

endmodule

// File: tb/tb_vx_lsu_csr_bridge.sv
// tb/tb_vx_lsu_csr_bridge.sv - directed self-checking bench for vx_lsu_csr_bridge
module tb_vx_lsu_csr_bridge;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [1:0]   req_op = '0;
    logic [3:0]   req_mask = '0;
    logic [47:0]  req_addr = '0;
    logic [127:0] req_data = '0;
    logic [7:0]   req_tag = '0;
    logic         csr_read_enable;
    logic [11:0]  csr_read_addr;
    logic [31:0]  csr_read_data;
    logic         csr_write_enable;
    logic [11:0]  csr_write_addr;
    logic [31:0]  csr_write_data;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [3:0]   rsp_mask;
    logic [127:0] rsp_data;
    logic [7:0]   rsp_tag;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] csr_mem [0:4095];
    logic        pl_en = 1'b0;
    logic [11:0] pl_addr = '0;
    logic [31:0] pl_data = '0;

    always #5 clk = ~clk;

    assign csr_read_data = csr_mem[csr_read_addr];

    always @(posedge clk) begin
        if (csr_write_enable) csr_mem[csr_write_addr] <= csr_write_data;
        if (pl_en) csr_mem[pl_addr] <= pl_data;
    end

    vx_lsu_csr_bridge dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_mask(req_mask), .req_addr(req_addr), .req_data(req_data), .req_tag(req_tag),
        .csr_read_enable(csr_read_enable), .csr_read_addr(csr_read_addr),
        .csr_read_data(csr_read_data), .csr_write_enable(csr_write_enable),
        .csr_write_addr(csr_write_addr), .csr_write_data(csr_write_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_mask(rsp_mask),
        .rsp_data(rsp_data), .rsp_tag(rsp_tag)
    );

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk);
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Called just after a negedge; returns at the negedge of cycle 1.
    task automatic send(input logic [1:0] op, input logic [3:0] mask, input logic [47:0] addr,
                        input logic [127:0] data, input logic [7:0] tag);
        req_valid = 1'b1; req_op = op; req_mask = mask;
        req_addr = addr; req_data = data; req_tag = tag;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic finish_rsp;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_cmp++;
            if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || csr_read_enable !== 1'b0 || csr_write_enable !== 1'b0) begin
                n_err++;
                $display("FAIL reset_idle c%0d: got rdy=%b vld=%b re=%b we=%b want 1 0 0 0", c, req_ready, rsp_valid, csr_read_enable, csr_write_enable);
            end
        end
        n_cmp++;
        if (rsp_data !== 128'h0 || rsp_tag !== 8'h0 || rsp_mask !== 4'h0) begin
            n_err++;
            $display("FAIL reset_rsp: got data=%h tag=%h mask=%h want 0", rsp_data, rsp_tag, rsp_mask);
        end
    endtask

    task automatic test_read;
        preload(12'h300, 32'hAA);
        preload(12'h301, 32'hBB);
        send(2'd0, 4'b1010, {12'h301, 12'h0, 12'h300, 12'h0}, '0, 8'h5A);
        n_cmp++;
        if (csr_read_enable !== 1'b1 || csr_read_addr !== 12'h300 || csr_write_enable !== 1'b0 || req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL read_c1: got re=%b ra=%h we=%b rdy=%b want 1 300 0 0", csr_read_enable, csr_read_addr, csr_write_enable, req_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (csr_read_enable !== 1'b1 || csr_read_addr !== 12'h301 || csr_write_enable !== 1'b0 || rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL read_c2: got re=%b ra=%h we=%b vld=%b want 1 301 0 0", csr_read_enable, csr_read_addr, csr_write_enable, rsp_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b1 || csr_read_enable !== 1'b0) begin
            n_err++;
            $display("FAIL read_c3_valid: got vld=%b re=%b want 1 0", rsp_valid, csr_read_enable);
        end
        n_cmp++;
        if (rsp_data !== {32'hBB, 32'h0, 32'hAA, 32'h0} || rsp_tag !== 8'h5A || rsp_mask !== 4'b1010) begin
            n_err++;
            $display("FAIL read_rsp: got data=%h tag=%h mask=%b want 000000bb00000000000000aa00000000 5a 1010", rsp_data, rsp_tag, rsp_mask);
        end
        finish_rsp();
        n_cmp++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL read_done: got vld=%b rdy=%b want 0 1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_set_clear;
        preload(12'h340, 32'h0F);
        send(2'd2, 4'b0001, {36'h0, 12'h340}, {96'h0, 32'hF0}, 8'h11);
        n_cmp++;
        if (csr_write_enable !== 1'b1 || csr_write_addr !== 12'h340 || csr_write_data !== 32'hFF) begin
            n_err++;
            $display("FAIL set_write: got we=%b wa=%h wd=%h want 1 340 ff", csr_write_enable, csr_write_addr, csr_write_data);
        end
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_data !== 128'h0F) begin
            n_err++;
            $display("FAIL set_rsp: got vld=%b data=%h want 1 0f", rsp_valid, rsp_data);
        end
        finish_rsp();
        send(2'd3, 4'b0001, {36'h0, 12'h340}, {96'h0, 32'h03}, 8'h12);
        n_cmp++;
        if (csr_write_enable !== 1'b1 || csr_write_data !== 32'hFC) begin
            n_err++;
            $display("FAIL clear_write: got we=%b wd=%h want 1 fc", csr_write_enable, csr_write_data);
        end
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_data !== 128'hFF || rsp_tag !== 8'h12) begin
            n_err++;
            $display("FAIL clear_rsp: got vld=%b data=%h tag=%h want 1 ff 12", rsp_valid, rsp_data, rsp_tag);
        end
        finish_rsp();
    endtask

    task automatic test_back_to_back;
        preload(12'h340, 32'h0);
        send(2'd1, 4'b1111, {4{12'h340}}, {32'd4, 32'd3, 32'd2, 32'd1}, 8'h77);
        for (int k = 1; k <= 4; k++) begin
            n_cmp++;
            if (csr_write_enable !== 1'b1 || csr_write_addr !== 12'h340 || csr_write_data !== 32'(k)) begin
                n_err++;
                $display("FAIL b2b_lane%0d: got we=%b wa=%h wd=%h want 1 340 %h", k - 1, csr_write_enable, csr_write_addr, csr_write_data, k);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_data !== {32'd3, 32'd2, 32'd1, 32'd0}) begin
            n_err++;
            $display("FAIL b2b_rsp: got vld=%b data=%h want 1 000000030000000200000001_00000000", rsp_valid, rsp_data);
        end
        n_cmp++;
        if (csr_mem[12'h340] !== 32'd4) begin
            n_err++;
            $display("FAIL b2b_final: got %h want 4", csr_mem[12'h340]);
        end
        finish_rsp();
    endtask

    task automatic test_empty_mask;
        send(2'd1, 4'b0000, {4{12'h123}}, {4{32'hDEAD}}, 8'h99);
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_data !== 128'h0 || csr_read_enable !== 1'b0 || csr_write_enable !== 1'b0) begin
            n_err++;
            $display("FAIL empty_c1: got vld=%b data=%h re=%b we=%b want 1 0 0 0", rsp_valid, rsp_data, csr_read_enable, csr_write_enable);
        end
        req_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_data !== 128'h0 || rsp_tag !== 8'h99 || rsp_mask !== 4'h0) begin
                n_err++;
                $display("FAIL empty_hold c%0d: got vld=%b rdy=%b data=%h tag=%h want 1 0 0 99", c, rsp_valid, req_ready, rsp_data, rsp_tag);
            end
        end
        req_valid = 1'b0;
        finish_rsp();
        n_cmp++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL empty_done: got vld=%b rdy=%b want 0 1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset_mid_access;
        preload(12'h350, 32'h0);
        preload(12'h351, 32'h0);
        preload(12'h352, 32'h0);
        preload(12'h353, 32'h0);
        send(2'd1, 4'b1111, {12'h353, 12'h352, 12'h351, 12'h350}, {32'h44, 32'h33, 32'h22, 32'h11}, 8'h42);
        @(negedge clk);
        n_cmp++;
        if (csr_write_addr !== 12'h351) begin
            n_err++;
            $display("FAIL mid_lane1: got wa=%h want 351", csr_write_addr);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_cmp++;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || csr_read_enable !== 1'b0 || csr_write_enable !== 1'b0) begin
                n_err++;
                $display("FAIL mid_after c%0d: got vld=%b rdy=%b re=%b we=%b want 0 1 0 0", c, rsp_valid, req_ready, csr_read_enable, csr_write_enable);
            end
        end
        n_cmp++;
        if (csr_mem[12'h350] !== 32'h11 || csr_mem[12'h351] !== 32'h0 || csr_mem[12'h352] !== 32'h0 || csr_mem[12'h353] !== 32'h0) begin
            n_err++;
            $display("FAIL mid_mem: got %h %h %h %h want 11 0 0 0", csr_mem[12'h350], csr_mem[12'h351], csr_mem[12'h352], csr_mem[12'h353]);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_set_clear();
        test_back_to_back();
        test_empty_mask();
        test_reset_mid_access();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vx_lsu_csr_bridge.md
Name: vx_lsu_csr_bridge

Overview:
- Multi-lane bridge between the LSU and the CSR unit.
- Accepts one LSU CSR request per handshake: per-lane addresses and data, lane mask, op and tag.
- Serializes the active lanes into single-lane CSR accesses, one per cycle. Supports read, write, set-bits and clear-bits.
- Returns one gathered per-lane response to the LSU with a valid/ready handshake.

Parameters:
- NUM_LANES, 4, number of LSU lanes per request (>=1)
- DATA_WIDTH, 32, CSR data width
- ADDR_WIDTH, 12, CSR address width
- TAG_WIDTH, 8, request tag width, echoed in the response

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when req_valid & req_ready
- req_op  in  2  0=READ, 1=WRITE, 2=SET (old|data), 3=CLEAR (old&~data)
- req_mask  in  NUM_LANES  active lanes
- req_addr  in  NUM_LANES*ADDR_WIDTH  per-lane CSR address
- req_data  in  NUM_LANES*DATA_WIDTH  per-lane write/operand data
- req_tag  in  TAG_WIDTH  request tag
- csr_read_enable  out  1  CSR read strobe
- csr_read_addr  out  ADDR_WIDTH  CSR read address
- csr_read_data  in  DATA_WIDTH  CSR read data, combinational, same cycle as strobe
- csr_write_enable  out  1  CSR write strobe, committed at clock edge
- csr_write_addr  out  ADDR_WIDTH  CSR write address
- csr_write_data  out  DATA_WIDTH  CSR write data
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
- rsp_mask  out  NUM_LANES  copy of the request mask
- rsp_data  out  NUM_LANES*DATA_WIDTH  per-lane old CSR value; zero for inactive lanes
- rsp_tag  out  TAG_WIDTH  copy of the request tag

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset). All state is cleared on a clk edge with reset=1.
- Reset values:
  - state=IDLE, req_ready=1, rsp_valid=0.
  - csr_read_enable=0, csr_write_enable=0.
  - rsp_mask/rsp_data/rsp_tag=0; CSR address/data outputs=0.
- FSM states: IDLE, ACCESS, RESPOND.
- IDLE:
  - req_ready=1.
  - On handshake: latch op/mask/addr/data/tag, clear the response data register, load pending=req_mask.
  - Next state is ACCESS if the mask is non-zero, else RESPOND.
- ACCESS:
  - req_ready=0.
  - Lane L is the lowest set bit of pending.
  - csr_read_enable=1 and csr_read_addr=addr[L] for all ops.
  - csr_write_enable=1 for WRITE/SET/CLEAR with csr_write_addr=addr[L].
  - csr_write_data: WRITE=data[L], SET=csr_read_data|data[L], CLEAR=csr_read_data&~data[L].
  - rsp_data[L] <= csr_read_data, so every op returns the old value.
  - pending[L] cleared. When pending becomes zero, next state is RESPOND.
  - Strobes are registered-state driven: asserted only in ACCESS, exactly one cycle per active lane.
- RESPOND:
  - rsp_valid=1; outputs hold stable until rsp_ready.
  - On rsp handshake: next state IDLE, rsp_valid=0.
  - A new request is accepted no earlier than the cycle after the response handshake; there is no overlap.
- Latency: request handshake at cycle 0, lane accesses in cycles 1..K (K=popcount(mask)), rsp_valid from cycle K+1. An empty mask gives rsp_valid at cycle 1.
- Same address in multiple lanes: lanes are processed in ascending order. A later lane reads the value committed by the earlier lane's write.
- Inactive lanes: no CSR access; rsp_data lane=0.
- CSR outputs are don't-care when strobes=0 but are driven to 0.
- Reset mid-ACCESS: the remaining lanes are dropped and no further strobes occur. Writes already committed stay committed. No response is issued.
- Reset mid-RESPOND: the response is dropped; rsp_valid=0 on the next cycle.
- rsp_ready is ignored outside RESPOND. req_valid is ignored outside IDLE.

Test Plan:
- Reset, then idle -> req_ready=1, rsp_valid=0, no strobes for 10 cycles.
- READ, mask=4'b1010, addr lane1=0x300, lane3=0x301, CSR model 0x300=0xAA, 0x301=0xBB -> read strobes at cycles 1 (0x300) and 2 (0x301), no write strobe, rsp_valid at cycle 3, rsp_data={0xBB,0,0xAA,0}, tag echoed.
- SET then CLEAR on 0x340 (init 0x0F): SET data=0xF0 -> write 0xFF, returns 0x0F; CLEAR data=0x03 -> write 0xFC, returns 0xFF.
- WRITE, all 4 lanes to addr 0x340, data 1,2,3,4 (init 0) -> returned old values 0,1,2,3, final CSR value 4.
- mask=0 -> no strobes, rsp_valid at cycle 1, rsp_data=0. Then hold rsp_ready=0 for 5 cycles -> outputs stable, req_ready=0; rsp_ready=1 -> IDLE next cycle.
- reset asserted during the 2nd lane of a 4-lane WRITE -> only lane 0 written, no rsp_valid, req_ready=1 after reset.
